dpram_be_clr: RTL and testbench

- Single-clock simple dual-port RAM: one write port, one read port.
- Successor to the plain dual-port RAM used for AIM65 display/RAM buffers.
- Adds per-byte write enables, selectable read-during-write behaviour, an optional output register with a read-valid strobe, and a hardware clear engine.
- The clear engine sweeps every word to a fill value after reset or on request, so the RAM holds defined contents without init files.

---
 rtl/dpram_be_clr.sv | 157 +++++++++++++++
 tb/tb_dpram_be_clr.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_be_clr.sv
// Single-clock simple dual-port RAM with byte-lane write enables, selectable
// read-during-write behaviour, optional output register and a hardware clear engine.
module dpram_be_clr #(
   parameter int                   MEM_WIDTH      = 8,
   parameter int                   MEM_DEPTH      = 1024,
   parameter int                   ADDR_WIDTH     = $clog2(MEM_DEPTH),
   parameter int                   BYTE_WIDTH     = 8,
   parameter int                   RDW_MODE       = 0,
   parameter int                   OUT_REG        = 0,
   parameter logic [MEM_WIDTH-1:0] CLEAR_VALUE    = '0,
   parameter int                   CLEAR_ON_RESET = 1
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              clear,
   output logic                              busy,
   input  logic                              we,
   input  logic [MEM_WIDTH/BYTE_WIDTH-1:0]   be,
   input  logic [ADDR_WIDTH-1:0]             w_addr,
   input  logic [MEM_WIDTH-1:0]              w_data,
   input  logic                              re,
   input  logic [ADDR_WIDTH-1:0]             r_addr,
   output logic [MEM_WIDTH-1:0]              r_data,
   output logic                              r_valid
);

   localparam int                    NB        = MEM_WIDTH / BYTE_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

   state_t                 state;
   state_t                 state_next;
   logic [ADDR_WIDTH-1:0]  cnt;
   logic [ADDR_WIDTH-1:0]  cnt_next;

   logic [MEM_WIDTH-1:0]   mem [MEM_DEPTH];

   logic                   w_in_range;
   logic                   r_in_range;
   logic                   w_ok;
   logic                   r_ok;
   logic [MEM_WIDTH-1:0]   rd_word;

   logic                   p1_valid;
   logic [MEM_WIDTH-1:0]   p1_data;

   // Addresses beyond the last word are legal on the ports but never touch memory.
   assign w_in_range = ({1'b0, w_addr} < DEPTH_EXT);
   assign r_in_range = ({1'b0, r_addr} < DEPTH_EXT);
   assign w_ok       = (state == IDLE) && we && w_in_range;
   assign r_ok       = (state == IDLE) && re;
   assign busy       = (state == CLEAR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RESET_STATE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // A clear request inside a sweep restarts it from word zero.
   always_comb begin
      state_next = state;
      cnt_next   = '0;
      case (state)
         IDLE: begin
            if (clear) begin
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            if (clear) begin
               state_next = CLEAR;
            end else if (cnt == LAST_ADDR) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[cnt] <= CLEAR_VALUE;
      end else if (w_ok) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
               mem[w_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // In new-data mode a colliding write is merged lane by lane into the read word.
   always_comb begin
      rd_word = '0;
      if (r_in_range) begin
         rd_word = mem[r_addr];
         if ((RDW_MODE == 1) && w_ok && (w_addr == r_addr)) begin
            for (int i = 0; i < NB; i++) begin
               if (be[i]) begin
                  rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p1_valid <= 1'b0;
         p1_data  <= '0;
      end else begin
         p1_valid <= r_ok;
         if (r_ok) begin
            p1_data <= rd_word;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                 p2_valid;
         logic [MEM_WIDTH-1:0] p2_data;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               p2_valid <= 1'b0;
               p2_data  <= '0;
            end else begin
               p2_valid <= p1_valid;
               if (p1_valid) begin
                  p2_data <= p1_data;
               end
            end
         end

         assign r_data  = p2_data;
         assign r_valid = p2_valid;
      end else begin : g_no_out_reg
         assign r_data  = p1_data;
         assign r_valid = p1_valid;
      end
   endgenerate

endmodule

// File: tb/tb_dpram_be_clr.sv
// Self-checking bench for dpram_be_clr: three configurations share one clock,
// exercised by a vector table, hand sequences and a randomized reference model.
module tb_dpram_be_clr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   logic reset_n_c;

   // A: 8-bit, depth 16, old-data RDW, latency 1, fill A5, clear on reset
   logic        clear_a, we_a, re_a, busy_a, r_valid_a;
   logic [0:0]  be_a;
   logic [3:0]  w_addr_a, r_addr_a;
   logic [7:0]  w_data_a, r_data_a;

   // B: 32-bit, depth 16, new-data RDW, latency 2, fill 0, clear on reset
   logic        clear_b, we_b, re_b, busy_b, r_valid_b;
   logic [3:0]  be_b;
   logic [3:0]  w_addr_b, r_addr_b;
   logic [31:0] w_data_b, r_data_b;

   // C: 8-bit, depth 10, new-data RDW, latency 1, fill 0, no clear on reset
   logic        clear_c, we_c, re_c, busy_c, r_valid_c;
   logic [0:0]  be_c;
   logic [3:0]  w_addr_c, r_addr_c;
   logic [7:0]  w_data_c, r_data_c;

   dpram_be_clr #(
      .MEM_WIDTH(8), .MEM_DEPTH(16), .RDW_MODE(0), .OUT_REG(0),
      .CLEAR_VALUE(8'hA5), .CLEAR_ON_RESET(1)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .clear(clear_a), .busy(busy_a),
      .we(we_a), .be(be_a), .w_addr(w_addr_a), .w_data(w_data_a),
      .re(re_a), .r_addr(r_addr_a), .r_data(r_data_a), .r_valid(r_valid_a)
   );

   dpram_be_clr #(
      .MEM_WIDTH(32), .MEM_DEPTH(16), .RDW_MODE(1), .OUT_REG(1),
      .CLEAR_VALUE(32'h0), .CLEAR_ON_RESET(1)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .clear(clear_b), .busy(busy_b),
      .we(we_b), .be(be_b), .w_addr(w_addr_b), .w_data(w_data_b),
      .re(re_b), .r_addr(r_addr_b), .r_data(r_data_b), .r_valid(r_valid_b)
   );

   dpram_be_clr #(
      .MEM_WIDTH(8), .MEM_DEPTH(10), .RDW_MODE(1), .OUT_REG(0),
      .CLEAR_VALUE(8'h00), .CLEAR_ON_RESET(0)
   ) dut_c (
      .clk(clk), .reset_n(reset_n_c), .clear(clear_c), .busy(busy_c),
      .we(we_c), .be(be_c), .w_addr(w_addr_c), .w_data(w_data_c),
      .re(re_c), .r_addr(r_addr_c), .r_data(r_data_c), .r_valid(r_valid_c)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       we;
      logic       be;
      logic [3:0] w_addr;
      logic [7:0] w_data;
      logic       re;
      logic [3:0] r_addr;
      logic       exp_valid;
      logic [7:0] exp_data;
   } vec_t;

   typedef struct {
      logic        valid;
      logic [31:0] data;
   } rd_t;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus_a(input vec_t v);
      we_a     = v.we;
      be_a     = v.be;
      w_addr_a = v.w_addr;
      w_data_a = v.w_data;
      re_a     = v.re;
      r_addr_a = v.r_addr;
   endtask

   function automatic logic [31:0] merge32(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] lanes);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
      end
      return res;
   endfunction

   // Counts cycles with busy high, starting at the current sample point.
   task automatic count_busy_a(output int n, output int valids);
      n = 0;
      valids = 0;
      while (busy_a && n < 100) begin
         n++;
         tick();
         if (busy_a && r_valid_a) valids++;
      end
   endtask

   task automatic count_busy_b(output int n);
      n = 0;
      while (busy_b && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic count_busy_c(output int n);
      n = 0;
      while (busy_c && n < 100) begin
         n++;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t        vecs[8];
      logic [7:0]  mem_a[16];
      logic [31:0] mem_b[16];
      rd_t         pipe_b[$];
      rd_t         e;
      logic [7:0]  last_a;
      logic [31:0] last_b;
      int          n;
      int          valids;
      logic        exp_v_a;
      logic [7:0]  exp_d_a;

      vecs[0] = '{1'b1, 1'b1, 4'd5, 8'h10, 1'b0, 4'd0, 1'b0, 8'hA5};
      vecs[1] = '{1'b1, 1'b1, 4'd5, 8'h20, 1'b1, 4'd5, 1'b1, 8'h10};
      vecs[2] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b1, 8'h20};
      vecs[3] = '{1'b1, 1'b0, 4'd3, 8'h77, 1'b1, 4'd3, 1'b1, 8'hA5};
      vecs[4] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 8'hA5};
      vecs[5] = '{1'b1, 1'b1, 4'd2, 8'h3C, 1'b1, 4'd7, 1'b1, 8'hA5};
      vecs[6] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b1, 8'h3C};
      vecs[7] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h3C};

      reset_n = 1'b0; reset_n_c = 1'b0;
      clear_a = 0; we_a = 0; re_a = 0; be_a = '0; w_addr_a = '0; r_addr_a = '0; w_data_a = '0;
      clear_b = 0; we_b = 0; re_b = 0; be_b = '0; w_addr_b = '0; r_addr_b = '0; w_data_b = '0;
      clear_c = 0; we_c = 0; re_c = 0; be_c = '0; w_addr_c = '0; r_addr_c = '0; w_data_c = '0;

      tick();
      tick();
      check_output("reset_busy_a", 32'(busy_a), 32'd1);
      check_output("reset_rvalid_a", 32'(r_valid_a), 32'd0);
      check_output("reset_rdata_a", 32'(r_data_a), 32'd0);
      check_output("reset_busy_c", 32'(busy_c), 32'd0);

      reset_n = 1'b1; reset_n_c = 1'b1;
      count_busy_a(n, valids);
      check_output("sweep_len_a", 32'(n), 32'd16);
      check_output("idle_busy_c", 32'(busy_c), 32'd0);

      for (int i = 0; i < 16; i++) begin
         re_a = 1'b1;
         r_addr_a = 4'(i);
         tick();
         check_output("fill_rvalid_a", 32'(r_valid_a), 32'd1);
         check_output("fill_rdata_a", 32'(r_data_a), 32'hA5);
      end
      re_a = 1'b0;

      for (int i = 0; i < 8; i++) begin
         apply_stimulus_a(vecs[i]);
         tick();
         check_output("vec_rvalid_a", 32'(r_valid_a), 32'(vecs[i].exp_valid));
         check_output("vec_rdata_a", 32'(r_data_a), 32'(vecs[i].exp_data));
      end
      we_a = 0; re_a = 0;

      // B: byte-lane merge, new-data collision and two-cycle read pipeline
      we_b = 1; be_b = 4'hF; w_addr_b = 4'd3; w_data_b = 32'h11223344;
      tick();
      be_b = 4'b0101; w_data_b = 32'hAABBCCDD;
      tick();
      we_b = 0; re_b = 1; r_addr_b = 4'd3;
      tick();
      re_b = 0;
      check_output("be_lat1_rvalid_b", 32'(r_valid_b), 32'd0);
      tick();
      check_output("be_rvalid_b", 32'(r_valid_b), 32'd1);
      check_output("be_rdata_b", r_data_b, 32'h11BB33DD);

      we_b = 1; be_b = 4'hF; w_addr_b = 4'd5; w_data_b = 32'h10;
      tick();
      w_data_b = 32'h20; re_b = 1; r_addr_b = 4'd5;
      tick();
      we_b = 0; re_b = 0;
      tick();
      check_output("rdw_new_b", r_data_b, 32'h20);
      we_b = 1; be_b = 4'b0010; w_data_b = 32'hFFFFFFFF; re_b = 1;
      tick();
      we_b = 0; re_b = 0;
      tick();
      check_output("rdw_merge_b", r_data_b, 32'h0000FF20);

      we_b = 1; be_b = 4'hF;
      w_addr_b = 4'd0; w_data_b = 32'hA0; tick();
      w_addr_b = 4'd1; w_data_b = 32'hB1; tick();
      w_addr_b = 4'd2; w_data_b = 32'hC2; tick();
      we_b = 0; re_b = 1;
      r_addr_b = 4'd0; tick();
      check_output("stream0_rvalid_b", 32'(r_valid_b), 32'd0);
      r_addr_b = 4'd1; tick();
      check_output("stream1_rvalid_b", 32'(r_valid_b), 32'd1);
      check_output("stream1_rdata_b", r_data_b, 32'hA0);
      r_addr_b = 4'd2; tick();
      re_b = 0;
      check_output("stream2_rdata_b", r_data_b, 32'hB1);
      tick();
      check_output("stream3_rvalid_b", 32'(r_valid_b), 32'd1);
      check_output("stream3_rdata_b", r_data_b, 32'hC2);
      tick();
      check_output("stream_hold_rvalid_b", 32'(r_valid_b), 32'd0);
      check_output("stream_hold_rdata_b", r_data_b, 32'hC2);

      // A: restart mid-sweep with writes and reads attempted during busy
      clear_a = 1; tick(); clear_a = 0;
      check_output("clear_rise_a", 32'(busy_a), 32'd1);
      for (int i = 0; i < 7; i++) tick();
      clear_a = 1; we_a = 1; be_a = 1'b1; w_addr_a = 4'd0; w_data_a = 8'h55; re_a = 1; r_addr_a = 4'd1;
      tick();
      clear_a = 0;
      count_busy_a(n, valids);
      we_a = 0; re_a = 0;
      check_output("restart_len_a", 32'(n), 32'd16);
      check_output("busy_rvalid_count_a", 32'(valids), 32'd0);
      check_output("post_busy_rvalid_a", 32'(r_valid_a), 32'd0);
      re_a = 1; r_addr_a = 4'd0; tick();
      check_output("blocked_write_a", 32'(r_data_a), 32'hA5);
      r_addr_a = 4'd2; tick();
      re_a = 0;
      check_output("reclear_a", 32'(r_data_a), 32'hA5);

      clear_b = 1; tick(); clear_b = 0;
      count_busy_b(n);
      check_output("clear_len_b", 32'(n), 32'd16);

      // Randomized traffic against a plain array model
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 8'hA5;
         mem_b[i] = 32'h0;
      end
      last_a = 8'hA5;
      last_b = 32'hC2;
      pipe_b.delete();
      pipe_b.push_back('{1'b0, 32'h0});
      for (int k = 0; k < 300; k++) begin
         we_a = 1'($urandom_range(0, 1)); be_a = 1'($urandom_range(0, 1));
         w_addr_a = 4'($urandom_range(0, 15)); w_data_a = 8'($urandom);
         re_a = 1'($urandom_range(0, 1)); r_addr_a = 4'($urandom_range(0, 15));
         we_b = 1'($urandom_range(0, 1)); be_b = 4'($urandom_range(0, 15));
         w_addr_b = 4'($urandom_range(0, 15)); w_data_b = $urandom;
         re_b = 1'($urandom_range(0, 1)); r_addr_b = 4'($urandom_range(0, 15));
         if (k % 7 == 0) r_addr_b = w_addr_b;

         exp_v_a = re_a;
         exp_d_a = mem_a[r_addr_a];
         if (we_a && be_a[0]) mem_a[w_addr_a] = w_data_a;

         e.valid = re_b;
         e.data  = mem_b[r_addr_b];
         if (we_b && w_addr_b == r_addr_b) e.data = merge32(e.data, w_data_b, be_b);
         if (we_b) mem_b[w_addr_b] = merge32(mem_b[w_addr_b], w_data_b, be_b);
         pipe_b.push_back(e);

         tick();
         if (exp_v_a) last_a = exp_d_a;
         check_output("rand_rvalid_a", 32'(r_valid_a), 32'(exp_v_a));
         check_output("rand_rdata_a", 32'(r_data_a), 32'(last_a));
         e = pipe_b.pop_front();
         if (e.valid) last_b = e.data;
         check_output("rand_rvalid_b", 32'(r_valid_b), 32'(e.valid));
         check_output("rand_rdata_b", r_data_b, last_b);
      end
      we_a = 0; re_a = 0; we_b = 0; re_b = 0;

      // C: depth 10, out-of-range accesses, reset in the middle of a sweep
      clear_c = 1; tick(); clear_c = 0;
      count_busy_c(n);
      check_output("clear_len_c", 32'(n), 32'd10);
      we_c = 1; be_c = 1'b1; w_addr_c = 4'd12; w_data_c = 8'h77; tick();
      w_addr_c = 4'd9; w_data_c = 8'h99; tick();
      we_c = 0; re_c = 1; r_addr_c = 4'd12; tick();
      check_output("oor_rvalid_c", 32'(r_valid_c), 32'd1);
      check_output("oor_rdata_c", 32'(r_data_c), 32'd0);
      r_addr_c = 4'd2; tick();
      check_output("no_alias_c", 32'(r_data_c), 32'd0);
      r_addr_c = 4'd9; tick();
      check_output("last_word_c", 32'(r_data_c), 32'h99);
      re_c = 0;
      we_c = 1; w_addr_c = 4'd5; w_data_c = 8'h10; tick();
      w_data_c = 8'h20; re_c = 1; r_addr_c = 4'd5; tick();
      we_c = 0; re_c = 0;
      check_output("rdw_new_c", 32'(r_data_c), 32'h20);

      clear_c = 1; re_c = 1; r_addr_c = 4'd9; tick();
      clear_c = 0; re_c = 0;
      check_output("clear_cycle_busy_c", 32'(busy_c), 32'd1);
      check_output("clear_cycle_rvalid_c", 32'(r_valid_c), 32'd1);
      check_output("clear_cycle_rdata_c", 32'(r_data_c), 32'h99);
      #2 reset_n_c = 1'b0;
      #1;
      check_output("async_busy_c", 32'(busy_c), 32'd0);
      check_output("async_rvalid_c", 32'(r_valid_c), 32'd0);
      check_output("async_rdata_c", 32'(r_data_c), 32'd0);
      tick();
      reset_n_c = 1'b1;
      tick();
      check_output("no_restart_c", 32'(busy_c), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
